// File: rtl/axil_offset_mem_pkg.sv
// Shared constants for the HP0 memory stand-in and its AXI4-Lite plumbing.
package axil_offset_mem_pkg;

   // Address width of the HP0 port as seen by the PL.
   localparam int unsigned HP0_ADDR_W = 32;

   // AXI response encodings.
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4_lite_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport m (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
             rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport s (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
             rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_mem_core.sv
// Byte-enabled word RAM: one write port, one synchronous read port.
// A read and a write to the same word on the same edge return the old word.
module axil_mem_core #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4096,
   localparam int unsigned STRB_W = DATA_W / 8,
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);
   // Contents are deliberately not reset; only the read register is.
   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-lane write, lane i enabled by wstrb[i].
   always_ff @(posedge aclk) begin
      if (we) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (wstrb[i]) begin
               mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   // Read register only loads on re, so it holds while the R beat is stalled.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axil_offset_mem.sv
// AXI4-Lite slave over an internal RAM, standing in for PS DDR behind HP0.
// Every AW/AR address is translated by a runtime offset before indexing.
module axil_offset_mem
   import axil_offset_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = HP0_ADDR_W,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4096
) (
   input  logic              aclk,
   input  logic              aresetn,
   axi4_lite_if.s            axi,
   input  logic [ADDR_W-1:0] offset
);
   localparam int unsigned STRB_W     = DATA_W / 8;
   localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
   localparam int unsigned IDX_W      = $clog2(DEPTH);

   logic [ADDR_W-1:0] aw_ea, ar_ea;
   logic [IDX_W-1:0]  aw_idx, ar_idx;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;

   logic              awready_q, wready_q, bvalid_q;
   logic              aw_pend_q, w_pend_q;
   logic [IDX_W-1:0]  waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic              arready_q, rvalid_q;
   logic [DATA_W-1:0] rdata;

   // Translation wraps in ADDR_W bits; high bits above the index simply alias.
   assign aw_ea  = axi.awaddr + offset;
   assign ar_ea  = axi.araddr + offset;
   assign aw_idx = aw_ea[BYTE_SHIFT +: IDX_W];
   assign ar_idx = ar_ea[BYTE_SHIFT +: IDX_W];

   assign aw_hs  = axi.awvalid & awready_q;
   assign w_hs   = axi.wvalid & wready_q;
   assign b_hs   = bvalid_q & axi.bready;
   assign ar_hs  = axi.arvalid & arready_q;
   assign r_hs   = rvalid_q & axi.rready;
   assign commit = aw_pend_q & w_pend_q;

   // Write channel: AW and W captured independently, committed together one edge later.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         if (aw_hs) begin
            awready_q <= 1'b0;
            aw_pend_q <= 1'b1;
            waddr_q   <= aw_idx;
         end
         if (w_hs) begin
            wready_q <= 1'b0;
            w_pend_q <= 1'b1;
            wdata_q  <= axi.wdata;
            wstrb_q  <= axi.wstrb;
         end
         if (commit) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            bvalid_q  <= 1'b1;
         end
         // Ready lines stay low through the response so only one write is in flight.
         if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
         end
      end
   end

   // Read channel: RAM read fires on the AR handshake edge, giving one read per two cycles.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
      end else begin
         if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
         end
         if (r_hs) begin
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
         end
      end
   end

   axil_mem_core #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_core (
      .aclk   (aclk),
      .aresetn(aresetn),
      .we     (commit),
      .waddr  (waddr_q),
      .wdata  (wdata_q),
      .wstrb  (wstrb_q),
      .re     (ar_hs),
      .raddr  (ar_idx),
      .rdata  (rdata)
   );

   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = AXI_RESP_OKAY;
   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rresp   = AXI_RESP_OKAY;
   assign axi.rdata   = rdata;

   // prot is ignored and address bits outside the index alias away.
   logic unused_bits;
   assign unused_bits = ^{axi.awprot, axi.arprot, aw_ea, ar_ea};

endmodule

// File: tb/tb_axil_offset_mem.sv
// Directed bench for axil_offset_mem with a word model and response scoreboards.
module tb_axil_offset_mem;
   import axil_offset_mem_pkg::*;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] off     = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_model [int];
   logic [31:0] rq [$];
   logic [1:0]  bq [$];
   logic [31:0] got;

   axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   axil_offset_mem #(
      .ADDR_W(32),
      .DATA_W(32),
      .DEPTH (4096)
   ) dut (
      .aclk   (aclk),
      .aresetn(aresetn),
      .axi    (axi),
      .offset (off)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      logic [31:0] ea;
      ea = a + off;
      return int'((ea >> 2) & 32'h0000_0FFF);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int i;
      i = idx_of(a);
      return mem_model.exists(i) ? mem_model[i] : 32'h0;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      w = model_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      mem_model[idx_of(a)] = w;
   endtask

   // Called at a negedge. W is raised w_delay cycles after AW; bready held low b_hold cycles.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_delay, input int b_hold);
      bit aw_ok, w_ok, aw_now, w_now;
      int n;
      aw_ok = 0; w_ok = 0; n = 0;
      model_write(a, d, s);
      bq.push_back(AXI_RESP_OKAY);
      axi.awaddr = a; axi.awvalid = 1'b1;
      axi.wdata = d; axi.wstrb = s; axi.bready = 1'b0;
      while (!(aw_ok && w_ok) && n < 20) begin
         if (n == w_delay && !w_ok) axi.wvalid = 1'b1;
         aw_now = axi.awvalid && axi.awready;
         w_now  = axi.wvalid && axi.wready;
         @(negedge aclk);
         n++;
         if (aw_now) begin aw_ok = 1; axi.awvalid = 1'b0; end
         if (w_now) begin w_ok = 1; axi.wvalid = 1'b0; end
         if (aw_ok && !w_ok) check("awready_wait", 64'(axi.awready), 64'd0);
      end
      check("wr_hs_done", 64'(aw_ok && w_ok), 64'd1);
      check("bvalid_early", 64'(axi.bvalid), 64'd0);
      @(negedge aclk);
      check("bvalid_lat", 64'(axi.bvalid), 64'd1);
      for (int i = 0; i < b_hold; i++) begin
         @(negedge aclk);
         check("bvalid_hold", 64'(axi.bvalid), 64'd1);
         check("awready_hold", 64'(axi.awready), 64'd0);
         check("wready_hold", 64'(axi.wready), 64'd0);
      end
      check("bresp", 64'(axi.bresp), 64'(bq.pop_front()));
      axi.bready = 1'b1;
      @(negedge aclk);
      axi.bready = 1'b0;
      check("bvalid_clr", 64'(axi.bvalid), 64'd0);
      check("awready_back", 64'(axi.awready), 64'd1);
      check("wready_back", 64'(axi.wready), 64'd1);
   endtask

   // Called at a negedge. rready held low `hold` cycles while a competing AR is offered.
   task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] data);
      int n;
      logic [31:0] first;
      n = 0;
      rq.push_back(model_read(a));
      axi.araddr = a; axi.arvalid = 1'b1;
      while (!axi.arready && n < 20) begin @(negedge aclk); n++; end
      check("ar_ready_idle", 64'(axi.arready), 64'd1);
      @(negedge aclk);
      axi.arvalid = 1'b0;
      check("rvalid_lat", 64'(axi.rvalid), 64'd1);
      check("arready_busy", 64'(axi.arready), 64'd0);
      first = axi.rdata;
      for (int i = 0; i < hold; i++) begin
         axi.araddr = a ^ 32'h40; axi.arvalid = 1'b1;
         @(negedge aclk);
         check("rvalid_hold", 64'(axi.rvalid), 64'd1);
         check("rdata_stable", 64'(axi.rdata), 64'(first));
         check("arready_hold", 64'(axi.arready), 64'd0);
      end
      axi.arvalid = 1'b0;
      axi.araddr  = a;
      data = axi.rdata;
      check("rresp", 64'(axi.rresp), 64'(AXI_RESP_OKAY));
      check("rdata_sb", 64'(data), 64'(rq.pop_front()));
      axi.rready = 1'b1;
      @(negedge aclk);
      axi.rready = 1'b0;
      check("rvalid_clr", 64'(axi.rvalid), 64'd0);
      check("arready_back", 64'(axi.arready), 64'd1);
   endtask

   initial begin
      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

      // Reset and idle state
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_awready", 64'(axi.awready), 64'd1);
      check("rst_wready", 64'(axi.wready), 64'd1);
      check("rst_arready", 64'(axi.arready), 64'd1);
      check("rst_bvalid", 64'(axi.bvalid), 64'd0);
      check("rst_rvalid", 64'(axi.rvalid), 64'd0);
      check("rst_rdata", 64'(axi.rdata), 64'd0);
      axi_read(32'h0, 0, got);
      check("rd_zero", 64'(got), 64'h0);

      // Offset translation
      off = 32'h0000_1000;
      axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
      off = 32'h0;
      axi_read(32'h1010, 0, got);
      check("rd_offset", 64'(got), 64'hDEAD_BEEF);

      // Byte strobes
      axi_write(32'h20, 32'h1122_3344, 4'hF, 0, 0);
      axi_write(32'h20, 32'hAABB_CCDD, 4'h5, 0, 0);
      axi_read(32'h20, 0, got);
      check("rd_strb", 64'(got), 64'h11BB_33DD);

      // AW three cycles ahead of W, B stalled two cycles
      axi_write(32'h24, 32'h5555_AAAA, 4'hF, 3, 2);
      axi_read(32'h24, 4, got);
      check("rd_late_w", 64'(got), 64'h5555_AAAA);

      // Aliasing above DEPTH and offset wrap-around
      axi_write(32'h4000, 32'h5A5A_A5A5, 4'hF, 0, 0);
      axi_read(32'h0, 0, got);
      check("rd_alias", 64'(got), 64'h5A5A_A5A5);
      off = 32'hFFFF_FFFC;
      axi_write(32'h8, 32'h0123_4567, 4'hF, 0, 0);
      off = 32'h0;
      axi_read(32'h4, 0, got);
      check("rd_wrap", 64'(got), 64'h0123_4567);

      // Same-edge read and write commit to one word: read sees old data
      axi_write(32'h30, 32'hCAFE_F00D, 4'hF, 0, 0);
      rq.push_back(model_read(32'h30));
      model_write(32'h30, 32'h0BAD_F00D, 4'hF);
      bq.push_back(AXI_RESP_OKAY);
      axi.awaddr = 32'h30; axi.awvalid = 1'b1;
      axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      @(negedge aclk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      axi.araddr = 32'h30; axi.arvalid = 1'b1;
      @(negedge aclk);
      axi.arvalid = 1'b0;
      check("coll_bvalid", 64'(axi.bvalid), 64'd1);
      check("coll_bresp", 64'(axi.bresp), 64'(bq.pop_front()));
      check("coll_rvalid", 64'(axi.rvalid), 64'd1);
      check("coll_rdata_sb", 64'(axi.rdata), 64'(rq.pop_front()));
      check("coll_rdata_old", 64'(axi.rdata), 64'hCAFE_F00D);
      axi.bready = 1'b1; axi.rready = 1'b1;
      @(negedge aclk);
      axi.bready = 1'b0; axi.rready = 1'b0;
      check("coll_done", 64'({axi.bvalid, axi.rvalid}), 64'd0);
      axi_read(32'h30, 0, got);
      check("rd_after_coll", 64'(got), 64'h0BAD_F00D);

      // Reset in the middle of a read and a half-written write
      axi.araddr = 32'h20; axi.arvalid = 1'b1;
      axi.awaddr = 32'h20; axi.awvalid = 1'b1;
      @(negedge aclk);
      axi.arvalid = 1'b0; axi.awvalid = 1'b0;
      check("mid_rvalid", 64'(axi.rvalid), 64'd1);
      check("mid_awready", 64'(axi.awready), 64'd0);
      #2 aresetn = 1'b0;
      #1;
      check("arst_awready", 64'(axi.awready), 64'd1);
      check("arst_arready", 64'(axi.arready), 64'd1);
      check("arst_rvalid", 64'(axi.rvalid), 64'd0);
      check("arst_bvalid", 64'(axi.bvalid), 64'd0);
      check("arst_rdata", 64'(axi.rdata), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      axi_read(32'h20, 0, got);
      check("rd_retained", 64'(got), 64'h11BB_33DD);
      axi_write(32'h44, 32'h7777_8888, 4'hC, 1, 0);
      axi_read(32'h44, 0, got);
      check("rd_post_rst", 64'(got), 64'h7777_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
